// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter
// (and a future receiver).
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick marks the last cycle of each CLKS_PER_BIT window.
// Asserting clear restarts the window at count 0 on the next cycle.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge rclk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO one byte at a time and sends each byte
// as an 8N1 frame on tx, LSB first.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_re,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [IW-1:0]        bit_idx;
  logic                 tick;
  logic                 clear;
  logic                 can_pop;

  assign can_pop = enable && !fifo_empty;
  // Restart the bit window whenever the state is about to change, so every
  // state begins at count 0 and a frame never drifts.
  assign clear   = (state_nxt != state);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .rclk  (rclk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge rclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (can_pop) state_nxt = POP;
      POP:     state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_idx == LAST_BIT) state_nxt = STOP;
      STOP:    if (tick) state_nxt = can_pop ? POP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if (state == LOAD) shift <= fifo_data;
      else if (state == DATA && tick) shift <= shift >> 1;

      if (state != DATA)  bit_idx <= '0;
      else if (tick)      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Outputs decode registered state only; pulses are masked while reset is
  // held so the FIFO is never popped and no completion is reported.
  always_comb begin
    tx      = UART_IDLE_LEVEL;
    fifo_re = 1'b0;
    tx_done = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      POP:     fifo_re = !reset;
      START:   tx = UART_START_LEVEL;
      DATA:    tx = shift[0];
      STOP:    tx_done = tick && !reset;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a registered-read FIFO model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       rclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_re, tx, busy, tx_done;

  int vecs = 0;
  int errs = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .rclk       (rclk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 rclk = ~rclk;

  // FIFO model: written from the stimulus at negedge, read at posedge.
  logic [7:0] fmem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge rclk) begin
    if (fifo_re && wr_cnt != rd_cnt) begin
      fifo_data <= fmem[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Read-strobe observer: pulse count and protocol violations.
  int   cyc = 0;
  int   re_cnt = 0;
  int   re_viol = 0;
  logic prev_re = 1'b0;
  always @(posedge rclk) begin
    cyc = cyc + 1;
    if (fifo_re) begin
      re_cnt = re_cnt + 1;
      if (fifo_empty || prev_re || reset) re_viol = re_viol + 1;
    end
    prev_re = fifo_re;
  end

  // Line decoder sampling mid-bit, plus tx_done position tracking.
  logic [7:0] rx_buf [0:255];
  logic [7:0] rx_sh = 8'h00;
  int   rx_n = 0;
  int   rx_t = 0;
  bit   rx_act = 1'b0;
  int   frame_err = 0;
  int   done_cnt = 0;
  int   done_bad = 0;
  int   end_cyc = 0;
  bit   have_end = 1'b0;
  int   last_gap = -1;
  always @(negedge rclk) begin
    if (tx_done) begin
      done_cnt = done_cnt + 1;
      if (!rx_act || rx_t != 10*CPB - 2) done_bad = done_bad + 1;
    end
    if (reset) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1; rx_t = 0; rx_sh = 8'h00;
        if (have_end) last_gap = cyc - end_cyc - 1;
      end
    end else begin
      rx_t = rx_t + 1;
      if (rx_t >= CPB + CPB/2 && rx_t < 9*CPB && (rx_t - CPB/2) % CPB == 0)
        rx_sh = {tx, rx_sh[7:1]};
      if (rx_t == 9*CPB + CPB/2 && tx !== 1'b1) frame_err = frame_err + 1;
      if (rx_t == 10*CPB - 1) begin
        rx_buf[rx_n] = rx_sh; rx_n = rx_n + 1;
        rx_act = 1'b0; end_cyc = cyc; have_end = 1'b1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_cnt] = b;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge rclk);
    vecs++; if (tx !== 1'b1)      begin errs++; $display("FAIL reset_tx got %b exp 1", tx); end
    vecs++; if (fifo_re !== 1'b0) begin errs++; $display("FAIL reset_re got %b exp 0", fifo_re); end
    vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    vecs++; if (tx_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", tx_done); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad_re, bad_tx, bad_busy;
    bad_re = 0; bad_tx = 0; bad_busy = 0;
    enable = 1'b1;
    repeat (100) begin
      @(negedge rclk);
      if (fifo_re !== 1'b0) bad_re++;
      if (tx !== 1'b1)      bad_tx++;
      if (busy !== 1'b0)    bad_busy++;
    end
    vecs++; if (bad_re != 0)   begin errs++; $display("FAIL idle_re cycles_with_re %0d exp 0", bad_re); end
    vecs++; if (bad_tx != 0)   begin errs++; $display("FAIL idle_tx cycles_low %0d exp 0", bad_tx); end
    vecs++; if (bad_busy != 0) begin errs++; $display("FAIL idle_busy cycles_busy %0d exp 0", bad_busy); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp_tx;
    int re0, t;
    b = 8'hA5; re0 = re_cnt;
    push(b);
    t = 0;
    while (fifo_re !== 1'b1 && t < 10) begin @(negedge rclk); t++; end
    vecs++; if (fifo_re !== 1'b1) begin errs++; $display("FAIL single_pop got %b exp 1", fifo_re); end
    vecs++; if (busy !== 1'b1)    begin errs++; $display("FAIL single_busy_pop got %b exp 1", busy); end
    @(negedge rclk);
    vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL single_load_tx got %b exp 1", tx); end
    for (int n = 0; n < 10*CPB; n++) begin
      @(negedge rclk);
      if (n < CPB) exp_tx = 1'b0;
      else if (n < 9*CPB) exp_tx = b[(n - CPB) / CPB];
      else exp_tx = 1'b1;
      vecs++;
      if (tx !== exp_tx) begin errs++; $display("FAIL single_wave cyc %0d got %b exp %b", n+1, tx, exp_tx); end
      vecs++;
      if (tx_done !== (n == 10*CPB - 1)) begin
        errs++; $display("FAIL single_done cyc %0d got %b exp %b", n+1, tx_done, (n == 10*CPB - 1));
      end
    end
    @(negedge rclk);
    vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL single_idle busy %b exp 0", busy); end
    vecs++; if (re_cnt - re0 != 1)   begin errs++; $display("FAIL single_re_cnt got %0d exp 1", re_cnt - re0); end
    vecs++; if (rx_buf[rx_n-1] !== b) begin errs++; $display("FAIL single_byte got %h exp %h", rx_buf[rx_n-1], b); end
  endtask

  task automatic test_back_to_back();
    int n0, re0, t;
    n0 = rx_n; re0 = re_cnt;
    push(8'h55); push(8'h0F);
    t = 0;
    while (rx_n < n0 + 2 && t < 300) begin @(negedge rclk); t++; end
    vecs++; if (rx_n < n0 + 2) begin errs++; $display("FAIL b2b_timeout frames %0d exp 2", rx_n - n0); end
    vecs++; if (rx_buf[n0] !== 8'h55)   begin errs++; $display("FAIL b2b_byte0 got %h exp 55", rx_buf[n0]); end
    vecs++; if (rx_buf[n0+1] !== 8'h0F) begin errs++; $display("FAIL b2b_byte1 got %h exp 0f", rx_buf[n0+1]); end
    vecs++; if (last_gap != 2)          begin errs++; $display("FAIL b2b_gap got %0d exp 2", last_gap); end
    repeat (3) @(negedge rclk);
    vecs++; if (re_cnt - re0 != 2) begin errs++; $display("FAIL b2b_re_cnt got %0d exp 2", re_cnt - re0); end
    vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL b2b_idle busy %b exp 0", busy); end
  endtask

  task automatic test_enable_drop();
    int n0, re0, t;
    n0 = rx_n; re0 = re_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    t = 0;
    while (!(rx_act && rx_t >= 2*CPB && rx_t < 8*CPB) && t < 100) begin @(negedge rclk); t++; end
    enable = 1'b0;
    t = 0;
    while ((busy === 1'b1 || rx_act) && t < 100) begin @(negedge rclk); t++; end
    repeat (20) @(negedge rclk);
    vecs++; if (re_cnt - re0 != 1)    begin errs++; $display("FAIL drop_re_cnt got %0d exp 1", re_cnt - re0); end
    vecs++; if (rx_n - n0 != 1)       begin errs++; $display("FAIL drop_frames got %0d exp 1", rx_n - n0); end
    vecs++; if (rx_buf[n0] !== 8'h11) begin errs++; $display("FAIL drop_byte1 got %h exp 11", rx_buf[n0]); end
    vecs++; if (wr_cnt - rd_cnt != 2) begin errs++; $display("FAIL drop_fifo_level got %0d exp 2", wr_cnt - rd_cnt); end
    enable = 1'b1;
    t = 0;
    while (rx_n < n0 + 3 && t < 300) begin @(negedge rclk); t++; end
    vecs++; if (rx_buf[n0+1] !== 8'h22) begin errs++; $display("FAIL resume_byte2 got %h exp 22", rx_buf[n0+1]); end
    vecs++; if (rx_buf[n0+2] !== 8'h33) begin errs++; $display("FAIL resume_byte3 got %h exp 33", rx_buf[n0+2]); end
    repeat (3) @(negedge rclk);
    vecs++; if (re_cnt - re0 != 3) begin errs++; $display("FAIL resume_re_cnt got %0d exp 3", re_cnt - re0); end
  endtask

  task automatic test_reset_mid();
    int n0, d0, t;
    n0 = rx_n; d0 = done_cnt;
    push(8'hFF); push(8'h3C);
    t = 0;
    while (tx !== 1'b0 && t < 20) begin @(negedge rclk); t++; end
    vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL rstmid_start got %b exp 0", tx); end
    repeat (14) @(negedge rclk);
    reset = 1'b1;
    @(negedge rclk);
    vecs++; if (tx !== 1'b1)   begin errs++; $display("FAIL rstmid_tx got %b exp 1", tx); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    @(negedge rclk);
    reset = 1'b0;
    vecs++; if (done_cnt != d0) begin errs++; $display("FAIL rstmid_no_done got %0d exp %0d", done_cnt, d0); end
    t = 0;
    while (rx_n < n0 + 1 && t < 100) begin @(negedge rclk); t++; end
    vecs++; if (rx_n - n0 != 1)       begin errs++; $display("FAIL rstmid_frames got %0d exp 1", rx_n - n0); end
    vecs++; if (rx_buf[n0] !== 8'h3C) begin errs++; $display("FAIL rstmid_next_byte got %h exp 3c", rx_buf[n0]); end
    vecs++; if (done_cnt - d0 != 1)   begin errs++; $display("FAIL rstmid_done_cnt got %0d exp 1", done_cnt - d0); end
    vecs++; if (wr_cnt != rd_cnt)     begin errs++; $display("FAIL rstmid_fifo_level got %0d exp 0", wr_cnt - rd_cnt); end
  endtask

  task automatic test_drain();
    int n0, re0, t;
    n0 = rx_n; re0 = re_cnt;
    for (int i = 0; i < 16; i++) push(8'(i));
    t = 0;
    while (rx_n < n0 + 16 && t < 1000) begin @(negedge rclk); t++; end
    vecs++; if (rx_n - n0 != 16) begin errs++; $display("FAIL drain_frames got %0d exp 16", rx_n - n0); end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (rx_buf[n0+i] !== 8'(i)) begin errs++; $display("FAIL drain_byte%0d got %h exp %h", i, rx_buf[n0+i], 8'(i)); end
    end
    repeat (3) @(negedge rclk);
    vecs++; if (re_cnt - re0 != 16) begin errs++; $display("FAIL drain_re_cnt got %0d exp 16", re_cnt - re0); end
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL drain_empty got %b exp 1", fifo_empty); end
    vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL drain_idle busy %b exp 0", busy); end
    vecs++; if (tx !== 1'b1)         begin errs++; $display("FAIL drain_idle tx %b exp 1", tx); end
    vecs++; if (frame_err != 0)      begin errs++; $display("FAIL stop_bits bad %0d exp 0", frame_err); end
    vecs++; if (re_viol != 0)        begin errs++; $display("FAIL re_protocol violations %0d exp 0", re_viol); end
    vecs++; if (done_bad != 0)       begin errs++; $display("FAIL done_position misplaced %0d exp 0", done_bad); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
